// File: rtl/uart_baud_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_baud_ctrl_if
//   Bundles the control and tick signals of the baud-tick scheduler.
//   master : the side that enables ticking, reports TX activity and offers
//            new rate settings (UART core or bench).
//   slave  : the scheduler itself.
//
//   en         enable tick generation
//   busy_tx    TX frame in flight; rate changes are deferred while high
//   cfg_valid  new phase increment offered
//   cfg_inc    phase increment (0 = stop)
//   cfg_ready  offer accepted when cfg_valid && cfg_ready at a clock edge
//   tick_os    one-cycle oversample pulse
//   tick_mid   one-cycle pulse at the middle of each bit
//   tick_bit   one-cycle pulse at each bit boundary
//   active     scheduler is running (state other than IDLE)
//   cur_inc    increment currently in force
// -----------------------------------------------------------------------------
interface uart_baud_ctrl_if #(
    parameter int ACC_W = 24
);
    logic             en;
    logic             busy_tx;
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_ready;
    logic             tick_os;
    logic             tick_mid;
    logic             tick_bit;
    logic             active;
    logic [ACC_W-1:0] cur_inc;

    modport master (
        output en, busy_tx, cfg_valid, cfg_inc,
        input  cfg_ready, tick_os, tick_mid, tick_bit, active, cur_inc
    );

    modport slave (
        input  en, busy_tx, cfg_valid, cfg_inc,
        output cfg_ready, tick_os, tick_mid, tick_bit, active, cur_inc
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// -----------------------------------------------------------------------------
// uart_baud_ctrl
//   Programmable baud-tick scheduler. A fractional phase accumulator advances
//   by cur_inc every clock; each carry out of the accumulator is one
//   oversample tick. Every OSR-th tick marks a bit boundary, and the tick
//   half way through the bit marks the mid-bit sampling point.
//   Rate changes offered while a TX frame is in flight are parked in a
//   pending register and applied once the transmitter goes idle.
//
//   clk_in  system clock
//   rst     synchronous reset, active low
//   bus     uart_baud_ctrl_if.slave (control inputs, tick outputs)
// -----------------------------------------------------------------------------
module uart_baud_ctrl #(
    parameter int ACC_W  = 24,
    parameter int OSR    = 16,
    parameter int CLK_HZ = 50_000_000
) (
    input logic             clk_in,
    input logic             rst,
    uart_baud_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(OSR);

    // The os_cnt wrap relies on OSR being a power of two.
    if (OSR < 4 || (OSR & (OSR - 1)) != 0 || CLK_HZ <= 0) begin : g_param_check
        $error("uart_baud_ctrl: OSR must be a power of two >= 4 and CLK_HZ > 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_os_cnt;
    logic [ACC_W-1:0]   r_cur_inc;
    logic [ACC_W-1:0]   r_pend_inc;
    logic               r_tick_os;
    logic               r_tick_mid;
    logic               r_tick_bit;
    logic               r_active;

    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_cfg_ready;
    logic               w_accept;
    logic               w_acc_en;

    assign w_sum       = {1'b0, r_acc} + {1'b0, r_cur_inc};
    assign w_carry     = w_sum[ACC_W];
    assign w_cfg_ready = (r_state != PEND);
    assign w_accept    = bus.cfg_valid && w_cfg_ready;

    // Accumulate on every RUN/PEND edge that is neither a disable nor an
    // apply. Accepting a deferred change (RUN with busy_tx) keeps ticking.
    assign w_acc_en = bus.en &&
                      ((r_state == RUN  && !(w_accept && !bus.busy_tx)) ||
                       (r_state == PEND && bus.busy_tx));

    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values; a later assignment in the same edge overrides an
    // earlier one, which is how apply/disable clear what accumulate wrote.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_cur_inc  <= '0;
            r_pend_inc <= '0;
            r_tick_os  <= 1'b0;
            r_tick_mid <= 1'b0;
            r_tick_bit <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_tick_os  <= 1'b0;
            r_tick_mid <= 1'b0;
            r_tick_bit <= 1'b0;

            if (w_acc_en) begin
                r_acc      <= w_sum[ACC_W-1:0];
                r_tick_os  <= w_carry;
                r_tick_bit <= w_carry && (r_os_cnt == CNT_W'(OSR - 1));
                r_tick_mid <= w_carry && (r_os_cnt == CNT_W'(OSR / 2 - 1));
                if (w_carry) begin
                    r_os_cnt <= r_os_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                IDLE: begin
                    r_acc    <= '0;
                    r_os_cnt <= '0;
                    // A config accepted this edge wins; RUN entry is judged
                    // on the registered increment, so it follows one edge later.
                    if (w_accept) begin
                        r_cur_inc <= bus.cfg_inc;
                    end else if (bus.en && r_cur_inc != '0) begin
                        r_state  <= RUN;
                        r_active <= 1'b1;
                    end
                end

                RUN: begin
                    if (!bus.en) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                        r_acc    <= '0;
                        r_os_cnt <= '0;
                    end else if (w_accept && !bus.busy_tx) begin
                        r_cur_inc <= bus.cfg_inc;
                        r_acc     <= '0;
                        r_os_cnt  <= '0;
                        r_state   <= (bus.cfg_inc == '0) ? IDLE : RUN;
                        r_active  <= (bus.cfg_inc != '0);
                    end else if (w_accept) begin
                        r_pend_inc <= bus.cfg_inc;
                        r_state    <= PEND;
                    end
                end

                PEND: begin
                    // Disable still applies the parked value but always lands
                    // in IDLE; otherwise apply once the frame has finished.
                    if (!bus.en || !bus.busy_tx) begin
                        r_cur_inc <= r_pend_inc;
                        r_acc     <= '0;
                        r_os_cnt  <= '0;
                        if (!bus.en || r_pend_inc == '0) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= RUN;
                            r_active <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                    r_acc    <= '0;
                    r_os_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.tick_os   = r_tick_os;
    assign bus.tick_mid  = r_tick_mid;
    assign bus.tick_bit  = r_tick_bit;
    assign bus.active    = r_active;
    assign bus.cur_inc   = r_cur_inc;
endmodule
